// File: rtl/commit_unit_if.sv
// commit_unit_if: ROB-head / register-file / map-table / data-memory bundle
// for the in-order commit stage.
//   master : ROB/memory side, drives the head entry, its tag and ready flag,
//            and mem_ack. Receives the retire pulse and all write-side outputs.
//   slave  : commit unit, the mirror image of master.
// Signals:
//   head_entry  ROB head entry, packed as rob_entry_t
//   head_ready  head value and address are both ready
//   head_tag    ROB tag of the head entry
//   mem_ack     data memory accepted the store write
//   rob_retire  combinational retire pulse; the ROB advances its head on it
//   rf_wr_*     registered register-file write port
//   map_clear_* registered map-table clear (only if the entry still holds the tag)
//   mem_*       registered store request, address and data
//   busy        a store is outstanding

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

interface commit_unit_if;
    typedef struct packed {
        logic                valid;
        logic                wr_mem;
        logic [4:0]          dest_reg;
        logic [`XLEN-1:0]    dest_addr;
        logic [`XLEN-1:0]    value;
        logic                store_dep;
        logic                value_ready;
        logic                address_ready;
    } rob_entry_t;

    rob_entry_t              head_entry;
    logic                    head_ready;
    logic [`ROB_TAG_LEN-1:0] head_tag;
    logic                    mem_ack;

    logic                    rob_retire;
    logic                    rf_wr_en;
    logic [4:0]              rf_wr_idx;
    logic [`XLEN-1:0]        rf_wr_data;
    logic                    map_clear_en;
    logic [4:0]              map_clear_reg;
    logic [`ROB_TAG_LEN-1:0] map_clear_tag;
    logic                    mem_req;
    logic [`XLEN-1:0]        mem_addr;
    logic [`XLEN-1:0]        mem_data;
    logic                    busy;

    modport master (
        output head_entry, head_ready, head_tag, mem_ack,
        input  rob_retire, rf_wr_en, rf_wr_idx, rf_wr_data,
               map_clear_en, map_clear_reg, map_clear_tag,
               mem_req, mem_addr, mem_data, busy
    );

    modport slave (
        input  head_entry, head_ready, head_tag, mem_ack,
        output rob_retire, rf_wr_en, rf_wr_idx, rf_wr_data,
               map_clear_en, map_clear_reg, map_clear_tag,
               mem_req, mem_addr, mem_data, busy
    );
endinterface

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage below the ROB.
// Non-store heads retire in the cycle they are valid and ready, and their
// register write and map-table clear appear as one-cycle registered pulses
// in the following cycle. Store heads first issue a latched req/ack write to
// data memory and retire in the cycle mem_ack arrives.
// Ports:
//   clock          system clock, all state changes on posedge
//   reset          synchronous active-high reset
//   bus            commit_unit_if.slave (head entry in, retire/rf/map/mem out)
//   retired_count  (COMMIT_STATS_EN only) retires seen, wraps
//   store_count    (COMMIT_STATS_EN only) store retires seen, wraps
// Optional feature macro: COMMIT_STATS_EN adds the two statistics counters.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 4
`endif

module commit_unit #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    commit_unit_if.slave         bus
`ifdef COMMIT_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] store_count
`endif
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STORE = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_rf_wr_en;
    logic [4:0]              r_rf_wr_idx;
    logic [`XLEN-1:0]        r_rf_wr_data;
    logic                    r_map_clear_en;
    logic [4:0]              r_map_clear_reg;
    logic [`ROB_TAG_LEN-1:0] r_map_clear_tag;
    logic                    r_mem_req;
    logic [`XLEN-1:0]        r_mem_addr;
    logic [`XLEN-1:0]        r_mem_data;

    logic                    w_head_ok;
    logic                    w_retire;
    logic                    w_unused_bits;

    // Head is eligible for any action only when valid and fully ready.
    assign w_head_ok = bus.head_entry.valid && bus.head_ready;

    // Retire: non-store in IDLE, or the store completing on mem_ack.
    // Gating on w_head_ok keeps retire impossible for an invalid/unready head.
    assign w_retire = !reset && w_head_ok &&
                      ((r_state == S_STORE) ? bus.mem_ack : !bus.head_entry.wr_mem);

    // Per-operand ready bits and store_dep are already folded into head_ready.
    assign w_unused_bits = ^{bus.head_entry.store_dep,
                             bus.head_entry.value_ready,
                             bus.head_entry.address_ready};

    // Commit FSM with registered write-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_rf_wr_en      <= 1'b0;
            r_rf_wr_idx     <= '0;
            r_rf_wr_data    <= '0;
            r_map_clear_en  <= 1'b0;
            r_map_clear_reg <= '0;
            r_map_clear_tag <= '0;
            r_mem_req       <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= '0;
        end else begin
            // Register/map pulses last exactly one cycle.
            r_rf_wr_en      <= 1'b0;
            r_rf_wr_idx     <= '0;
            r_rf_wr_data    <= '0;
            r_map_clear_en  <= 1'b0;
            r_map_clear_reg <= '0;
            r_map_clear_tag <= '0;

            case (r_state)
                S_IDLE: begin
                    if (w_head_ok) begin
                        if (!bus.head_entry.wr_mem) begin
                            // x0 is never written and never renamed.
                            if (bus.head_entry.dest_reg != 5'd0) begin
                                r_rf_wr_en      <= 1'b1;
                                r_rf_wr_idx     <= bus.head_entry.dest_reg;
                                r_rf_wr_data    <= bus.head_entry.value;
                                r_map_clear_en  <= 1'b1;
                                r_map_clear_reg <= bus.head_entry.dest_reg;
                                r_map_clear_tag <= bus.head_tag;
                            end
                        end else begin
                            // Latch the store so head changes cannot disturb it.
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= bus.head_entry.dest_addr;
                            r_mem_data <= bus.head_entry.value;
                            r_state    <= S_STORE;
                        end
                    end
                end
                S_STORE: begin
                    if (bus.mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                        r_mem_data <= '0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rob_retire    = w_retire;
    assign bus.rf_wr_en      = r_rf_wr_en;
    assign bus.rf_wr_idx     = r_rf_wr_idx;
    assign bus.rf_wr_data    = r_rf_wr_data;
    assign bus.map_clear_en  = r_map_clear_en;
    assign bus.map_clear_reg = r_map_clear_reg;
    assign bus.map_clear_tag = r_map_clear_tag;
    assign bus.mem_req       = r_mem_req;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_data      = r_mem_data;
    assign bus.busy          = (r_state == S_STORE);

`ifdef COMMIT_STATS_EN
    logic [CNT_WIDTH-1:0] r_retired_count;
    logic [CNT_WIDTH-1:0] r_store_count;

    // Retire statistics, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired_count <= '0;
            r_store_count   <= '0;
        end else begin
            if (w_retire) begin
                r_retired_count <= r_retired_count + CNT_WIDTH'(1);
            end
            if (w_retire && (r_state == S_STORE)) begin
                r_store_count <= r_store_count + CNT_WIDTH'(1);
            end
        end
    end

    assign retired_count = r_retired_count;
    assign store_count   = r_store_count;
`else
    logic [CNT_WIDTH-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the ROB. Consumes the ROB head entry and its ready flag, and issues a one-cycle retire pulse that the ROB uses to advance its head.
- On retire it writes register results to the architectural register file and clears matching map-table tags.
- Stores are performed to data memory through a req/ack handshake before they retire.

Parameters:
- CNT_WIDTH, 32, width of the statistics counters (only used when COMMIT_STATS_EN is defined).

Ports:
- clock  input  1  system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- head_entry  input  ROB_ENTRY  ROB head entry (valid, wr_mem, dest_reg, dest_addr, value, store_dep, value_ready, address_ready)
- head_ready  input  1  head entry's value and address are both ready
- head_tag  input  `ROB_TAG_LEN  ROB tag of the head entry
- mem_ack  input  1  data memory accepted the store write
- rob_retire  output  1  combinational; head retires at this clock edge
- rf_wr_en  output  1  registered; register-file write enable
- rf_wr_idx  output  5  registered; destination register
- rf_wr_data  output  `XLEN  registered; write data
- map_clear_en  output  1  registered; clear map entry if it still holds map_clear_tag
- map_clear_reg  output  5  registered; map-table index
- map_clear_tag  output  `ROB_TAG_LEN  registered; tag being retired
- mem_req  output  1  registered; store write request
- mem_addr  output  `XLEN  registered; store address
- mem_data  output  `XLEN  registered; store data
- busy  output  1  FSM is not in IDLE

Behaviour:
- Reset: FSM to IDLE. All registered outputs are 0. rob_retire is 0 while reset is high.
- FSM has two states: IDLE and STORE.
- IDLE, head_entry.valid && head_ready && !wr_mem:
  - rob_retire = 1 in this cycle N.
  - At edge N: rf_wr_en, rf_wr_idx, rf_wr_data, map_clear_en, map_clear_reg and map_clear_tag are loaded from the head entry. These outputs are visible in cycle N+1 for exactly one cycle.
  - If dest_reg == 0: rf_wr_en = 0 and map_clear_en = 0, but the entry still retires.
  - One retire per cycle is possible (back-to-back non-stores).
- IDLE, head valid && ready && wr_mem:
  - rob_retire = 0.
  - At the edge: mem_addr <= dest_addr, mem_data <= value, mem_req <= 1, state <= STORE.
  - Address and data are latched, so later head changes have no effect.
- STORE:
  - mem_req is held high and mem_addr/mem_data are held stable until mem_ack.
  - In a cycle with mem_ack = 1: rob_retire = 1 (combinational). At the edge mem_req <= 0 and state <= IDLE.
  - The next head is evaluated in the cycle after ack. No second request can be issued in the ack cycle.
  - No register writes and no map clears occur for stores.
- mem_ack while in IDLE or while mem_req = 0 is ignored.
- head_entry.valid = 0 or head_ready = 0: nothing happens and outputs default to 0 (the registered pulses deassert).
- Reset while in STORE: mem_req drops at that edge and no retire occurs. Memory must discard the abandoned request.
- rob_retire can never be 1 with head_ready = 0 or head_entry.valid = 0.
- busy = (state == STORE).

Optional Feature:
- Macro: COMMIT_STATS_EN.
- Defined:
  - Adds outputs retired_count [CNT_WIDTH-1:0] and store_count [CNT_WIDTH-1:0], both reset to 0.
  - retired_count increments at every edge where rob_retire = 1.
  - store_count increments at every store retire.
  - Both wrap modulo 2^CNT_WIDTH.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then head non-store, dest_reg=5, value=32'h1234, tag=2, head_ready=1 -> same cycle rob_retire=1; next cycle rf_wr_en=1, idx=5, data=32'h1234, map_clear_en=1, tag=2; the cycle after, all pulses are 0.
- Non-store with dest_reg=0 -> rob_retire=1, rf_wr_en=0, map_clear_en=0.
- Store with dest_addr=32'h100, value=32'hAB, mem_ack delayed 3 cycles:
  - mem_req=1 for 3 cycles with addr 32'h100 and data 32'hAB;
  - rob_retire=1 only in the ack cycle;
  - mem_req=0 the next cycle; busy high throughout.
- Three consecutive ready non-store heads (regs 1, 2, 3) -> three consecutive rob_retire pulses and three rf writes in cycles N+1..N+3.
- Reset asserted during STORE before ack -> mem_req=0 next cycle, no rob_retire, state IDLE; a following ack is ignored.
- COMMIT_STATS_EN: two non-stores and one store retired -> retired_count=3, store_count=1; after reset both are 0.
